// File: rtl/x2c_fifo_pkg.sv
// Shared defaults for the x2c synchronous FIFO family.
package x2c_fifo_pkg;
  localparam int X2C_FIFO_WIDTH     = 32;
  localparam int X2C_FIFO_PTR       = 10;
  localparam int X2C_FIFO_AF_MARGIN = 4;
  localparam int X2C_FIFO_AE_LVL    = 4;

  function automatic int x2c_fifo_depth(input int ptr);
    return 1 << ptr;
  endfunction
endpackage

// File: rtl/x2c_sdp_ram.sv
// Simple dual-port RAM, one clock, registered read output, no reset.
module x2c_sdp_ram #(
  parameter int WIDTH = 32,
  parameter int PTR   = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [PTR-1:0]   raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [2**PTR];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/x2c_ctrl_fifo_sync.sv
// Synchronous FIFO control: pointers, fill count, status/error flags and the
// optional first-word-fall-through prefetch around an x2c_sdp_ram store.
module x2c_ctrl_fifo_sync
  import x2c_fifo_pkg::*;
#(
  parameter int WIDTH  = X2C_FIFO_WIDTH,
  parameter int PTR    = X2C_FIFO_PTR,
  parameter int FWFT   = 0,
  parameter int AF_LVL = x2c_fifo_depth(X2C_FIFO_PTR) - X2C_FIFO_AF_MARGIN,
  parameter int AE_LVL = X2C_FIFO_AE_LVL
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic             almost_empty,
  output logic [PTR:0]     usedw,
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [PTR:0] DEPTH_W = (PTR+1)'(x2c_fifo_depth(PTR));
  localparam logic [PTR:0] AF_W    = (PTR+1)'(AF_LVL);
  localparam logic [PTR:0] AE_W    = (PTR+1)'(AE_LVL);
  localparam logic [PTR:0] ONE_W   = (PTR+1)'(1);

  logic [PTR:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR:0]     usedw_q, usedw_d, ram_cnt;
  logic             out_vld_q, out_vld_d, q_ok_q, q_ok_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_acc, rd_acc, fetch;
  logic [WIDTH-1:0] ram_rdata;

  // A request is accepted only when asserted on an edge where the matching
  // status flag (full for writes, empty for reads) is low; no other handshake.
  assign wr_acc       = wrreq & ~full;
  assign rd_acc       = rdreq & ~empty;
  assign full         = (usedw_q == DEPTH_W);
  assign empty        = (FWFT != 0) ? ~out_vld_q : (usedw_q == '0);
  assign almost_full  = (usedw_q >= AF_W);
  assign almost_empty = (usedw_q <= AE_W);
  assign usedw        = usedw_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign ram_cnt      = wr_ptr_q - rd_ptr_q;
  // The RAM output register is unreset, so q is masked until the first fetch.
  assign q            = q_ok_q ? ram_rdata : '0;

  always_comb begin
    fetch     = 1'b0;
    out_vld_d = 1'b0;
    if (FWFT != 0) begin
      // Keep the RAM output loaded with the head word whenever one is stored.
      fetch     = (ram_cnt != '0) && (!out_vld_q || rd_acc);
      out_vld_d = fetch || (out_vld_q && !rd_acc);
    end else begin
      fetch = rd_acc;
    end
    wr_ptr_d = wr_acc ? wr_ptr_q + ONE_W : wr_ptr_q;
    rd_ptr_d = fetch  ? rd_ptr_q + ONE_W : rd_ptr_q;
    q_ok_d   = q_ok_q | fetch;
    usedw_d  = usedw_q;
    if (wr_acc && !rd_acc)      usedw_d = usedw_q + ONE_W;
    else if (rd_acc && !wr_acc) usedw_d = usedw_q - ONE_W;
    ovf_d = err_clr ? 1'b0 : ovf_q;
    unf_d = err_clr ? 1'b0 : unf_q;
    if (wrreq && full)  ovf_d = 1'b1;
    if (rdreq && empty) unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      usedw_q   <= '0;
      out_vld_q <= 1'b0;
      q_ok_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      usedw_q   <= usedw_d;
      out_vld_q <= out_vld_d;
      q_ok_q    <= q_ok_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  x2c_sdp_ram #(.WIDTH(WIDTH), .PTR(PTR)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[PTR-1:0]),
    .wdata (data),
    .re    (fetch),
    .raddr (rd_ptr_q[PTR-1:0]),
    .rdata (ram_rdata)
  );
endmodule

// File: doc/x2c_ctrl_fifo_sync.md
X2C_CTRL_FIFO_SYNC -- requirements
Module: x2c_ctrl_fifo_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter PTR, default 10, pointer width; DEPTH = 2**PTR, default 1024.
REQ-003 SHALL have parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AF_LVL, default DEPTH-4, almost-full threshold in words.
REQ-005 SHALL have parameter AE_LVL, default 4, almost-empty threshold in words.
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  sole clock, rising edge; aclr  in  1  asynchronous active-high reset.
REQ-007 SHALL have the data ports: wrreq  in  1  write request; data  in  WIDTH  write data; rdreq  in  1  read request; q  out  WIDTH  read data.
REQ-008 SHALL have the status ports: full  out  1  no free slot; almost_full  out  1  usedw >= AF_LVL; empty  out  1  no readable word; almost_empty  out  1  usedw <= AE_LVL.
REQ-009 SHALL have the count and error ports: usedw  out  PTR+1  words held, 0..DEPTH; err_clr  in  1  clears sticky errors; overflow  out  1  sticky write-while-full; underflow  out  1  sticky read-while-empty.

Function
REQ-010 Write accept SHALL be wrreq & !full; the data word is stored at the write pointer on that clk edge.
REQ-011 Read accept SHALL be rdreq & !empty; the read pointer advances on that edge.
REQ-012 Pointers SHALL be PTR+1 bits (wrap bit + index) and wrap from 2**(PTR+1)-1 to 0 with no special handling.
REQ-013 usedw SHALL be registered: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-014 full SHALL equal (usedw == DEPTH); almost_full and almost_empty SHALL be compares of registered usedw, with no extra latency.
REQ-015 FWFT=0: empty SHALL equal (usedw == 0); q SHALL load the head word on the edge after an accepted read (1-cycle latency) and hold otherwise.
REQ-016 FWFT=1: q SHALL present the head word whenever empty=0; a write into an empty FIFO SHALL drop empty and present the word on q on the second edge after the write; rdreq pops the word with 0 cycles to data.
REQ-017 FWFT=1: usedw SHALL count every accepted, unread word, including the one held on q.
REQ-018 Simultaneous read and write when full SHALL accept the read and reject the write; overflow is set.
REQ-019 Simultaneous read and write when empty SHALL accept the write and reject the read; underflow is set.
REQ-020 Simultaneous read and write when neither full nor empty SHALL accept both; usedw and flags are unchanged.
REQ-021 overflow SHALL set on wrreq & full, underflow on rdreq & empty; both hold until err_clr=1 on an edge, and a set event on the same edge wins.
REQ-022 A rejected request SHALL change no pointer, no stored data, no usedw and no q.

Reset
REQ-023 aclr=1 SHALL asynchronously set: pointers 0, usedw 0, empty 1, almost_empty 1, full 0, almost_full 0, q 0, overflow 0, underflow 0; FWFT output-valid bit 0.
REQ-024 Reset mid-operation SHALL discard all contents; RAM contents are not reset and are never visible.
REQ-025 The first accepted request SHALL be at the first rising edge after aclr deasserts.

Structure
REQ-026 The default constants X2C_FIFO_WIDTH=32, X2C_FIFO_PTR=10, X2C_FIFO_AF_MARGIN=4 and X2C_FIFO_AE_LVL=4 SHALL live in the shared package x2c_fifo_pkg.
REQ-027 Storage SHALL be one sub-module, x2c_sdp_ram: simple dual-port, DEPTH x WIDTH, one clock, registered read, no reset, inferable as block RAM.
REQ-028 Pointer, count, flag, FWFT-prefetch and error logic SHALL live in x2c_ctrl_fifo_sync.

Verification
REQ-029 Reset, then write 0x00000001..0x00000400 (1024 words) -> full=1 after the 1024th write, almost_full=1 from usedw=1020, usedw=1024.
REQ-030 Continue the REQ-029 case with a 1025th write of 0xDEADBEEF -> overflow=1, usedw stays 1024, and readback is 0x1..0x400 in order.
REQ-031 FWFT=0: write 0xA5A5A5A5, then rdreq at the next cycle -> q=0xA5A5A5A5 one cycle later, empty=1, usedw=0; a further rdreq sets underflow=1.
REQ-032 FWFT=1: write 0x12345678 into an empty FIFO -> empty=0 and q=0x12345678 two edges later, with no rdreq.
REQ-033 Hold usedw=512 with wrreq=rdreq=1 for 3000 cycles (pointer wrap) -> usedw stays 512 and data order is preserved.
REQ-034 Assert aclr mid-burst at usedw=300 -> all outputs take the REQ-023 values at once; the next write/read returns the new word only.
